// File: rtl/led_breath_if.sv
// Control/status bundle for the breathing LED driver.
// master drives strobe and enable; slave returns LED pin, duty and phase.
interface led_breath_if #(
   parameter int PWM_W = 8
);
   logic             tick_i;
   logic             en_i;
   logic             led_o;
   logic [PWM_W-1:0] duty_o;
   logic [1:0]       phase_o;

   modport master (output tick_i, en_i, input led_o, duty_o, phase_o);
   modport slave  (input tick_i, en_i, output led_o, duty_o, phase_o);
endinterface

// File: rtl/led_breath.sv
// Breathing PWM LED driver: ramps duty up, holds, ramps down, holds, repeats.
// One registered cycle from counter to pin; duty only moves at PWM period boundaries.
module led_breath #(
   parameter int PWM_W      = 8,
   parameter int STEP       = 1,
   parameter int HOLD_TICKS = 16
) (
   input logic         clk_i,
   input logic         rst_i,
   led_breath_if.slave bus
);
   localparam int               HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [PWM_W-1:0] MAX       = {PWM_W{1'b1}};
   localparam logic [PWM_W:0]   STEP_X    = (PWM_W+1)'(STEP);
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {
      UP      = 2'd0,
      HOLD_HI = 2'd1,
      DOWN    = 2'd2,
      HOLD_LO = 2'd3
   } phase_t;

   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty;
   phase_t           state;
   logic [HW-1:0]    hold_cnt;
   logic             pend;
   logic             led;
   logic             wrap;
   logic             step;
   logic [PWM_W:0]   up_sum;

   assign wrap   = (pwm_cnt == MAX);
   // Ticks are latched across the period and consumed only at the wrap, so no runt pulses.
   assign step   = wrap && bus.en_i && (pend || bus.tick_i);
   assign up_sum = {1'b0, duty} + STEP_X;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_cnt  <= '0;
         duty     <= '0;
         state    <= UP;
         hold_cnt <= '0;
         pend     <= 1'b0;
         led      <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         led     <= bus.en_i && (pwm_cnt < duty);
         pend    <= wrap ? 1'b0 : (pend | bus.tick_i);
         if (step) begin
            case (state)
               UP: begin
                  if (up_sum >= {1'b0, MAX}) begin
                     duty     <= MAX;
                     hold_cnt <= '0;
                     state    <= HOLD_HI;
                  end else begin
                     duty <= up_sum[PWM_W-1:0];
                  end
               end
               HOLD_HI: begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     state    <= DOWN;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               DOWN: begin
                  if ({1'b0, duty} <= STEP_X) begin
                     duty     <= '0;
                     hold_cnt <= '0;
                     state    <= HOLD_LO;
                  end else begin
                     duty <= duty - STEP_X[PWM_W-1:0];
                  end
               end
               HOLD_LO: begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     state    <= UP;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               default: state <= UP;
            endcase
         end
      end
   end

   assign bus.led_o   = led;
   assign bus.duty_o  = duty;
   assign bus.phase_o = state;
endmodule

// File: tb/tb_led_breath.sv
// Directed bench: a PWM_W=4/STEP=4/HOLD_TICKS=2 instance walks the full breathing cycle,
// and a default-parameter instance exercises mid-sequence reset.
module tb_led_breath;
   logic clk = 1'b0;
   logic rst4;
   logic rst8;
   int   total = 0;
   int   bad   = 0;
   int   hi;

   always #5 clk = ~clk;

   led_breath_if #(.PWM_W(4)) bus4 ();
   led_breath_if #(.PWM_W(8)) bus8 ();

   led_breath #(.PWM_W(4), .STEP(4), .HOLD_TICKS(2)) dut4 (
      .clk_i (clk),
      .rst_i (rst4),
      .bus   (bus4)
   );

   led_breath dut8 (
      .clk_i (clk),
      .rst_i (rst8),
      .bus   (bus8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One 16-cycle PWM period of dut4, starting right after a wrap; tmask[i] ticks in the cycle where pwm_cnt==i.
   task automatic period4(input logic [15:0] tmask, output int high);
      high = 0;
      for (int i = 0; i < 16; i++) begin
         bus4.tick_i = tmask[i];
         cyc();
         high += int'(bus4.led_o);
      end
      bus4.tick_i = 1'b0;
   endtask

   task automatic period8(input logic t, output int high);
      high = 0;
      for (int i = 0; i < 256; i++) begin
         bus8.tick_i = (i == 0) ? t : 1'b0;
         cyc();
         high += int'(bus8.led_o);
      end
      bus8.tick_i = 1'b0;
   endtask

   task automatic st4(input string tag, input int d, input int p);
      chk({tag, "_duty"}, 32'(bus4.duty_o), 32'(d));
      chk({tag, "_phase"}, 32'(bus4.phase_o), 32'(p));
   endtask

   initial begin
      rst4 = 1'b1;
      rst8 = 1'b1;
      bus4.tick_i = 1'b1;
      bus4.en_i   = 1'b1;
      bus8.tick_i = 1'b0;
      bus8.en_i   = 1'b0;

      // Reset held with tick and enable asserted
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_led", 32'(bus4.led_o), 0);
         st4("rst", 0, 0);
      end
      rst4 = 1'b0;
      bus4.tick_i = 1'b0;
      cyc();
      chk("rel_led", 32'(bus4.led_o), 0);
      st4("rel", 0, 0);
      repeat (15) cyc();

      // Ramp up
      period4(16'h0001, hi); chk("p1_hi", 32'(hi), 0);  st4("up4", 4, 0);
      period4(16'h0001, hi); chk("p2_hi", 32'(hi), 4);  st4("up8", 8, 0);
      period4(16'h0001, hi); chk("p3_hi", 32'(hi), 8);  st4("up12", 12, 0);
      period4(16'h0001, hi); chk("p4_hi", 32'(hi), 12); st4("up15", 15, 1);

      // Hold high, ramp down, hold low, back to UP
      period4(16'h0001, hi); chk("p5_hi", 32'(hi), 15); st4("hh1", 15, 1);
      period4(16'h0001, hi); st4("hh2", 15, 2);
      period4(16'h0001, hi); st4("dn11", 11, 2);
      period4(16'h0001, hi); st4("dn7", 7, 2);
      period4(16'h0001, hi); chk("p9_hi", 32'(hi), 7);  st4("dn3", 3, 2);
      period4(16'h0001, hi); st4("dn0", 0, 3);
      period4(16'h0001, hi); chk("p11_hi", 32'(hi), 0); st4("hl1", 0, 3);
      period4(16'h0001, hi); st4("hl2", 0, 0);

      // Three ticks in a period collapse; tick on the wrap cycle is consumed by that wrap
      period4(16'h0421, hi); st4("coll", 4, 0);
      period4(16'h8000, hi); st4("wrap_tick", 8, 0);
      period4(16'h0000, hi); chk("no_extra_hi", 32'(hi), 8); st4("no_extra", 8, 0);

      // Enable gating
      bus4.en_i = 1'b0;
      for (int p = 0; p < 5; p++) begin
         period4(16'h0101, hi);
         chk("dis_hi", 32'(hi), 0);
         st4("dis", 8, 0);
      end
      bus4.en_i = 1'b1;
      period4(16'h0001, hi); chk("resume_hi", 32'(hi), 8); st4("resume", 12, 0);

      // Reset in the middle of a DOWN period
      period4(16'h0001, hi); st4("r15", 15, 1);
      period4(16'h0001, hi);
      period4(16'h0001, hi);
      period4(16'h0001, hi); st4("rdn", 11, 2);
      cyc();
      chk("pre_rst_led", 32'(bus4.led_o), 1);
      rst4 = 1'b1;
      bus4.tick_i = 1'b1;
      cyc();
      rst4 = 1'b0;
      bus4.tick_i = 1'b0;
      chk("mid_rst_led", 32'(bus4.led_o), 0);
      st4("mid_rst", 0, 0);
      period4(16'h0001, hi); st4("post_rst", 4, 0);

      // Default parameters: mid-sequence reset then first step gives 1
      bus8.en_i = 1'b1;
      bus8.tick_i = 1'b1;
      cyc();
      rst8 = 1'b0;
      bus8.tick_i = 1'b0;
      chk("d8_rst_duty", 32'(bus8.duty_o), 0);
      period8(1'b1, hi);
      period8(1'b1, hi);
      period8(1'b1, hi); chk("d8_hi2", 32'(hi), 2);
      chk("d8_duty3", 32'(bus8.duty_o), 3);
      chk("d8_phase3", 32'(bus8.phase_o), 0);
      cyc();
      chk("d8_pre_led", 32'(bus8.led_o), 1);
      rst8 = 1'b1;
      bus8.tick_i = 1'b1;
      cyc();
      rst8 = 1'b0;
      bus8.tick_i = 1'b0;
      chk("d8_mid_duty", 32'(bus8.duty_o), 0);
      chk("d8_mid_phase", 32'(bus8.phase_o), 0);
      chk("d8_mid_led", 32'(bus8.led_o), 0);
      period8(1'b1, hi);
      chk("d8_step1", 32'(bus8.duty_o), 1);
      chk("d8_step1_phase", 32'(bus8.phase_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
